mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single 64-bit memory port between the instruction cache and the data cache. It grants at most one requester per cycle, with data-cache priority and a bounded-starvation override for the instruction cache. It records which requester owns each outstanding memory tag and steers returning data tags only to that owner. It sits between `icache_2way`/dcache and the memory model, and produces the `Dcache_on_bus` signal that the icache consumes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied icache request cycles after which the icache gets priority; legal range 1-15.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `squash_flag` in 1: pipeline squash; disowns all icache-owned tags.
- `Icache2mem_command` in 2: BUS_NONE/BUS_LOAD from icache.
- `Icache2mem_addr` in `XLEN`: icache address, 8-byte aligned.
- `Dcache2mem_command` in 2: BUS_NONE/BUS_LOAD/BUS_STORE from dcache.
- `Dcache2mem_addr` in `XLEN`: dcache address.
- `Dcache2mem_data` in 64: store data.
- `mem2proc_response` in 4: memory acceptance tag; 0 means rejected.
- `mem2proc_data` in 64: returning load data.
- `mem2proc_tag` in 4: tag of returning data; 0 means none.
- `proc2mem_command` out 2: command to memory.
- `proc2mem_addr` out `XLEN`: address to memory.
- `proc2mem_data` out 64: store data to memory.
- `Dcache_on_bus` out 1: dcache holds the bus this cycle.
- `Imem2proc_response` out 4: response routed to icache.
- `Dmem2proc_response` out 4: response routed to dcache.
- `Imem2proc_tag` out 4: data tag routed to icache; 0 if not icache-owned.
- `Dmem2proc_tag` out 4: data tag routed to dcache; 0 if not dcache-owned.
- `mem2proc_data_out` out 64: `mem2proc_data` passed through to both caches.
- `outstanding_cnt` out 4: number of valid owner-table entries.

## Operation
- Grant logic is combinational within a cycle.
  - `i_req` = icache command != NONE.
  - `d_req` = dcache command != NONE.
  - `istarved` = `starve_cnt` >= `STARVE_LIMIT`.
- Grant rules:
  - `grant_d` = `d_req` && !(`i_req` && `istarved`).
  - `grant_i` = `i_req` && !`grant_d`.
- Bus mux:
  - Granted requester's command, addr and data go to memory.
  - `proc2mem_data` = `Dcache2mem_data` always.
  - With no grant: command BUS_NONE, addr 0.
- `Dcache_on_bus` = `grant_d`.
- Response routing:
  - `Imem2proc_response` = `grant_i` ? `mem2proc_response` : 0.
  - `Dmem2proc_response` = `grant_d` ? `mem2proc_response` : 0.
  - A response of 0 is a rejection; the requester retries. No arbiter state changes on a rejection.
- Owner table: entries 1..15, each holding {valid, owner (0=I, 1=D)}.
  - Set: on a granted BUS_LOAD with nonzero response, entry[response] <= {1, owner}.
  - Stores never allocate.
- Data return, when `mem2proc_tag` != 0 and entry valid:
  - Route the tag to the recorded owner; the other cache's tag output is 0.
  - Clear the entry at the clock edge.
  - Unknown or invalid tag: both routed tags are 0.
- Same-cycle clear and set of the same tag: set wins (memory reused the tag).
- Squash: on `squash_flag`, clear every valid I-owned entry at the edge, so late icache data is dropped.
  - A same-cycle icache allocation is still recorded, because the new fetch owns it.
  - A same-cycle icache data return is still routed that cycle (combinational), then cleared.
- Starvation counter, 4-bit saturating at 15:
  - Increments when `i_req` && !`grant_i`.
  - Clears when `grant_i` or !`i_req`.
- `outstanding_cnt`: registered popcount of valid entries, reflecting table state after the edge.
- Reset values:
  - Table cleared, `starve_cnt` 0, `outstanding_cnt` 0.
  - `proc2mem_command` is forced to BUS_NONE while `reset` is high.
  - Routed responses and tags are 0 during reset.

## Timing
- Request-to-memory latency is 0 cycles (same-cycle mux). The response is routed the same cycle.
- Table and counter updates are visible the next cycle.
- Data-tag routing is same-cycle, from the registered table.
- Reset mid-operation: all ownership is lost. Data arriving after reset deasserts with an old tag is dropped (routed tags 0).
- Icache maximum wait under continuous dcache traffic: `STARVE_LIMIT` + 1 cycles to grant.

## Test plan
- Reset: hold reset with both commands = LOAD.
  - `proc2mem_command` = NONE, both responses 0, `outstanding_cnt` = 0.
  - After release with only icache LOAD at 0x100 and response 3: `Imem2proc_response` = 3, `Dcache_on_bus` = 0, entry 3 = I.
- Contention: both LOAD, response 5.
  - `Dcache_on_bus` = 1, address = dcache addr, `Dmem2proc_response` = 5, `Imem2proc_response` = 0.
  - Later, `mem2proc_tag` = 5 gives `Dmem2proc_tag` = 5, `Imem2proc_tag` = 0, and the entry clears.
- Starvation: with `STARVE_LIMIT` = 4, hold both requesting.
  - Dcache is granted cycles 0-3; the icache is granted in cycle 4; the counter returns to 0.
- Squash: icache owns tags 2 and 7, dcache owns 4; pulse `squash_flag`.
  - Then tag 2 returning routes to neither cache, tag 4 routes to the dcache, and `outstanding_cnt` goes 3 -> 1 -> 0 as tag 4 returns.
- Tag reuse: tag 6 returns (owner D) in the same cycle the icache is granted with response 6.
  - Next cycle entry 6 = I, and `outstanding_cnt` is unchanged.
- Store and rejection:
  - Dcache STORE with response 9: no allocation, `outstanding_cnt` unchanged.
  - Response 0 to an icache LOAD: `Imem2proc_response` = 0 and no table change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory port between icache and dcache. Dcache wins by default,
// the icache is guaranteed a grant after a bounded wait, and load tags are steered to their owner.
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            squash_flag,
    input  logic [1:0]      Icache2mem_command,
    input  logic [XLEN-1:0] Icache2mem_addr,
    input  logic [1:0]      Dcache2mem_command,
    input  logic [XLEN-1:0] Dcache2mem_addr,
    input  logic [63:0]     Dcache2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic            Dcache_on_bus,
    output logic [3:0]      Imem2proc_response,
    output logic [3:0]      Dmem2proc_response,
    output logic [3:0]      Imem2proc_tag,
    output logic [3:0]      Dmem2proc_tag,
    output logic [63:0]     mem2proc_data_out,
    output logic [3:0]      outstanding_cnt
);

    localparam logic [1:0] BUS_NONE    = 2'd0;
    localparam logic [1:0] BUS_LOAD    = 2'd1;
    localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);
    localparam logic       OWNER_I     = 1'b0;

    // Owner table: bit n describes memory tag n; tag 0 means "no tag" and is never valid.
    logic [15:0] valid_q, valid_d;
    logic [15:0] owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  outstanding_q, outstanding_d;

    logic i_req, d_req, istarved;
    logic grant_i, grant_d;
    logic alloc;
    logic tag_hit;

    // Reset masks the requests so nothing reaches memory and no response is routed.
    always_comb begin
        i_req    = !reset && (Icache2mem_command != BUS_NONE);
        d_req    = !reset && (Dcache2mem_command != BUS_NONE);
        istarved = (starve_q >= LIMIT);
        grant_d  = d_req && !(i_req && istarved);
        grant_i  = i_req && !grant_d;
    end

    always_comb begin
        proc2mem_command   = BUS_NONE;
        proc2mem_addr      = '0;
        if (grant_d) begin
            proc2mem_command = Dcache2mem_command;
            proc2mem_addr    = Dcache2mem_addr;
        end else if (grant_i) begin
            proc2mem_command = Icache2mem_command;
            proc2mem_addr    = Icache2mem_addr;
        end
        proc2mem_data      = Dcache2mem_data;
        Dcache_on_bus      = grant_d;
        Imem2proc_response = grant_i ? mem2proc_response : 4'd0;
        Dmem2proc_response = grant_d ? mem2proc_response : 4'd0;
        mem2proc_data_out  = mem2proc_data;
        outstanding_cnt    = outstanding_q;
    end

    // Returning data is steered from the registered table, so a same-cycle squash still delivers it.
    always_comb begin
        tag_hit       = !reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
        Imem2proc_tag = 4'd0;
        Dmem2proc_tag = 4'd0;
        if (tag_hit) begin
            if (owner_q[mem2proc_tag] == OWNER_I) Imem2proc_tag = mem2proc_tag;
            else                                  Dmem2proc_tag = mem2proc_tag;
        end
    end

    assign alloc = (grant_i || grant_d) && (proc2mem_command == BUS_LOAD)
                   && (mem2proc_response != 4'd0);

    // NOTE: every _d starts from its _q value, so each path is fully assigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (squash_flag) begin
            for (int i = 1; i < 16; i++) begin
                if (owner_q[i] == OWNER_I) valid_d[i] = 1'b0;
            end
        end
        if (tag_hit) valid_d[mem2proc_tag] = 1'b0;
        // Allocation is applied last so a tag reused by memory in the same cycle stays owned.
        if (alloc) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant_d;
        end
        valid_d[0] = 1'b0;
        if (reset) begin
            valid_d = '0;
            owner_d = '0;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (i_req && !grant_i) starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
        if (reset) starve_d = 4'd0;
    end

    always_comb begin
        outstanding_d = 4'd0;
        for (int i = 1; i < 16; i++) begin
            outstanding_d = outstanding_d + {3'd0, valid_d[i]};
        end
    end

    // NOTE: the table is ordinary flops, so clearing it on reset is cheap and keeps ownership sane.
    always_ff @(posedge clock) begin
        valid_q       <= valid_d;
        owner_q       <= owner_d;
        starve_q      <= starve_d;
        outstanding_q <= outstanding_d;
    end

endmodule
